// File: rtl/jtoutrun_subarb_pkg.sv
// Shared definitions for the sub-CPU bus arbiter: state encoding and default timing.
`timescale 1ns/1ps
package jtoutrun_subarb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_REQ    = 3'd1;
  localparam state_t ST_OWN    = 3'd2;
  localparam state_t ST_ACCESS = 3'd3;
  localparam state_t ST_DONE   = 3'd4;
  localparam state_t ST_REL    = 3'd5;
  localparam state_t ST_COOL   = 3'd6;

  localparam logic [7:0] TOUT_DEFAULT    = 8'd200;
  localparam logic [1:0] HOLDOFF_DEFAULT = 2'd2;

  // States in which the main CPU holds the sub bus (BGACK asserted).
  function automatic logic owns_bus(input state_t s);
    return (s == ST_OWN) || (s == ST_ACCESS) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/jtoutrun_subarb.sv
// Lets the main CPU borrow the sub 68000 bus through BR/BG/BGACK, with grant timeout
// and a short hold-off after each release so the sub CPU always gets bus time.
`timescale 1ns/1ps
module jtoutrun_subarb
  import jtoutrun_subarb_pkg::*;
#(
  parameter logic [7:0] TOUT    = TOUT_DEFAULT,
  parameter logic [1:0] HOLDOFF = HOLDOFF_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cpu_cen,
  input  logic        creset,
  input  logic        main_cs,
  input  logic [15:0] bus_dout,
  input  logic        bus_ok,
  input  logic        cpu_BGn,
  input  logic        cpu_ASn,
  input  logic        cpu_DTACKn,
  output logic        cpu_BRn,
  output logic        cpu_BGACKn,
  output logic        sub_br,
  output logic [15:0] main_din,
  output logic        main_ok,
  output logic        tout_err
);

  state_t      state_q, state_d;
  logic [7:0]  req_cnt_q, req_cnt_d;
  logic [1:0]  hold_cnt_q, hold_cnt_d;
  logic [15:0] main_din_q, main_din_d;
  logic        tout_err_q, tout_err_d;
  logic        brn_q, brn_d;
  logic        bgackn_q, bgackn_d;
  logic        sub_br_q, sub_br_d;
  logic        main_ok_q, main_ok_d;
  logic [7:0]  req_inc;
  logic [2:0]  hold_inc;
  logic        grant_ok;

  assign req_inc  = (req_cnt_q == 8'hFF) ? req_cnt_q : req_cnt_q + 8'd1;
  assign hold_inc = {1'b0, hold_cnt_q} + 3'd1;
  // The 68k has really let go only once no cycle is in progress on the same tick.
  assign grant_ok = !cpu_BGn && cpu_ASn && cpu_DTACKn;

  always_comb begin
    state_d    = state_q;
    req_cnt_d  = req_cnt_q;
    hold_cnt_d = hold_cnt_q;
    main_din_d = main_din_q;
    tout_err_d = tout_err_q;
    case (state_q)
      ST_IDLE: begin
        if (main_cs && !main_ok_q) begin
          state_d   = ST_REQ;
          req_cnt_d = '0;
        end
      end
      ST_REQ: begin
        if (creset) begin
          state_d = ST_OWN;
        end else if (cpu_cen) begin
          if (grant_ok) begin
            state_d = ST_OWN;
          end else begin
            req_cnt_d = req_inc;
            if (req_inc >= TOUT) begin
              state_d    = ST_DONE;
              tout_err_d = 1'b1;
              main_din_d = 16'hFFFF;
            end
          end
        end
      end
      ST_OWN:    state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus_ok) begin
          main_din_d = bus_dout;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!main_cs) state_d = ST_REL;
      end
      ST_REL: begin
        if (cpu_cen) begin
          state_d    = (creset || HOLDOFF == 2'd0) ? ST_IDLE : ST_COOL;
          hold_cnt_d = '0;
        end
      end
      ST_COOL: begin
        if (creset) begin
          state_d = ST_IDLE;
        end else if (cpu_cen) begin
          hold_cnt_d = hold_inc[1:0];
          if (hold_inc >= {1'b0, HOLDOFF}) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs follow the state being entered so they change on the same edge.
    brn_d     = (state_d != ST_REQ);
    bgackn_d  = !owns_bus(state_d);
    sub_br_d  = (state_d == ST_ACCESS);
    main_ok_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      req_cnt_q  <= '0;
      hold_cnt_q <= '0;
      main_din_q <= '0;
      tout_err_q <= 1'b0;
      brn_q      <= 1'b1;
      bgackn_q   <= 1'b1;
      sub_br_q   <= 1'b0;
      main_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_cnt_q  <= req_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      main_din_q <= main_din_d;
      tout_err_q <= tout_err_d;
      brn_q      <= brn_d;
      bgackn_q   <= bgackn_d;
      sub_br_q   <= sub_br_d;
      main_ok_q  <= main_ok_d;
    end
  end

  assign cpu_BRn    = brn_q;
  assign cpu_BGACKn = bgackn_q;
  assign sub_br     = sub_br_q;
  assign main_din   = main_din_q;
  assign main_ok    = main_ok_q;
  assign tout_err   = tout_err_q;

endmodule

// File: tb/tb_jtoutrun_subarb.sv
// Randomised scoreboard bench for the sub-bus arbiter: the driver pushes the expected
// read result per access, a separate monitor pops it whenever main_ok rises.
`timescale 1ns/1ps
module tb_jtoutrun_subarb;

  localparam int TOUT_T = 200;
  localparam int HOLD_T = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cpu_cen = 1'b0;
  logic        creset = 1'b0;
  logic        main_cs = 1'b0;
  logic [15:0] bus_dout = 16'h0;
  logic        bus_ok = 1'b0;
  logic        cpu_BGn = 1'b1;
  logic        cpu_ASn = 1'b1;
  logic        cpu_DTACKn = 1'b1;
  logic        cpu_BRn, cpu_BGACKn, sub_br, main_ok, tout_err;
  logic [15:0] main_din;

  typedef struct packed {
    logic [15:0] din;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  logic err_model = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  jtoutrun_subarb dut (
    .clk        (clk),
    .rstn       (rstn),
    .cpu_cen    (cpu_cen),
    .creset     (creset),
    .main_cs    (main_cs),
    .bus_dout   (bus_dout),
    .bus_ok     (bus_ok),
    .cpu_BGn    (cpu_BGn),
    .cpu_ASn    (cpu_ASn),
    .cpu_DTACKn (cpu_DTACKn),
    .cpu_BRn    (cpu_BRn),
    .cpu_BGACKn (cpu_BGACKn),
    .sub_br     (sub_br),
    .main_din   (main_din),
    .main_ok    (main_ok),
    .tout_err   (tout_err)
  );

  always #5 clk = ~clk;

  // Irregular sub-CPU clock enable, changed only on falling edges.
  initial begin
    forever begin
      @(negedge clk);
      cpu_cen = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Advance one clock and look at the results just after the edge; cpu_cen still
  // shows the value that edge sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] d, input logic e);
    exp_t x;
    x.din = d;
    x.err = e;
    exp_q.push_back(x);
  endtask

  // Monitor: one scoreboard pop per completed access.
  initial begin
    logic ok_prev;
    exp_t e;
    ok_prev = 1'b0;
    forever begin
      step();
      if (main_ok && !ok_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_main_ok", main_ok, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("main_din", main_din, e.din);
          check("tout_err", tout_err, e.err);
          $display("txn: main_din=%04h tout_err=%0b (expected %04h/%0b)", main_din, tout_err, e.din, e.err);
        end
      end
      ok_prev = main_ok;
    end
  end

  task automatic wait_brn_low();
    for (int i = 0; i < 100 && cpu_BRn; i++) step();
    check("req_brn_low", cpu_BRn, 1'b0);
  endtask

  // Let any hold-off run out so the arbiter is back in IDLE.
  task automatic settle();
    int c;
    c = 0;
    for (int i = 0; i < 200 && c < 1 + HOLD_T; i++) begin
      step();
      if (cpu_cen) c++;
    end
    step();
  endtask

  task automatic normal_txn(input bit cr, input int gdel, input int as_hold, input bit drop_cs,
                            input int okdel, input bit b2b, input logic [15:0] data);
    int  cnt;
    bit  valid;
    bit  granted;
    int  hold;
    creset  = cr;
    cpu_BGn = 1'b1;
    cpu_ASn = 1'b1;
    cpu_DTACKn = 1'b1;
    main_cs = 1'b1;
    if (cr) begin
      step();
      step();
      check("creset_own", cpu_BGACKn, 1'b0);
    end else begin
      wait_brn_low();
      cnt = 0;
      for (int i = 0; i < 200 && cnt < gdel; i++) begin
        step();
        if (cpu_cen) cnt++;
      end
      cpu_BGn    = 1'b0;
      cpu_ASn    = (as_hold == 0);
      cpu_DTACKn = (as_hold == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      cnt = 0;
      granted = 1'b0;
      for (int i = 0; i < 100; i++) begin
        valid = !cpu_BGn && cpu_ASn && cpu_DTACKn;
        step();
        if (cpu_cen && !valid) cnt++;
        if (!cpu_BGACKn || (valid && cpu_cen)) begin
          check("grant_edge", !cpu_BGACKn, valid && cpu_cen);
          check("brn_at_grant", cpu_BRn, 1'b1);
          granted = 1'b1;
          break;
        end
        if (cnt >= as_hold) begin
          cpu_ASn = 1'b1;
          cpu_DTACKn = 1'b1;
        end
      end
      if (!granted) check("grant_wait", cpu_BGACKn, 1'b0);
      cpu_BGn = 1'b1;
    end
    for (int i = 0; i < 5 && !sub_br; i++) step();
    check("sub_br_on", sub_br, 1'b1);
    if (drop_cs) main_cs = 1'b0;
    for (int i = 0; i < okdel; i++) begin
      bus_dout = 16'($urandom);
      step();
      check("sub_br_hold", sub_br, 1'b1);
    end
    bus_dout = data;
    bus_ok = 1'b1;
    push_exp(data, err_model);
    step();
    bus_ok = 1'b0;
    bus_dout = 16'($urandom);
    check("sub_br_off", sub_br, 1'b0);
    check("main_ok_rise", main_ok, 1'b1);
    check("bgackn_done", cpu_BGACKn, 1'b0);
    if (!drop_cs) begin
      hold = $urandom_range(1, 3);
      repeat (hold) begin
        step();
        check("main_ok_hold", main_ok, 1'b1);
      end
      main_cs = 1'b0;
    end
    step();
    check("bgackn_rel", cpu_BGACKn, 1'b1);
    check("main_ok_rel", main_ok, 1'b0);
    if (b2b) begin
      main_cs = 1'b1;
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
        step();
        if (!cpu_BRn) break;
        if (cpu_cen) cnt++;
      end
      check("brn_after_holdoff", cpu_BRn, 1'b0);
      check("holdoff_ticks", cnt, cr ? 1 : 1 + HOLD_T);
    end else begin
      settle();
      repeat ($urandom_range(0, 4)) step();
    end
    creset = 1'b0;
  endtask

  task automatic timeout_txn();
    int cnt;
    bit sub_seen;
    cpu_BGn = 1'b1;
    main_cs = 1'b1;
    wait_brn_low();
    push_exp(16'hFFFF, 1'b1);
    err_model = 1'b1;
    cnt = 0;
    sub_seen = 1'b0;
    for (int i = 0; i < 3000 && !main_ok; i++) begin
      step();
      if (cpu_cen) cnt++;
      if (sub_br) sub_seen = 1'b1;
    end
    check("tout_ticks", cnt, TOUT_T);
    check("tout_no_sub_br", sub_seen, 1'b0);
    check("tout_brn_high", cpu_BRn, 1'b1);
    main_cs = 1'b0;
    step();
    check("tout_main_ok_rel", main_ok, 1'b0);
    settle();
  endtask

  task automatic reset_midop();
    main_cs = 1'b1;
    wait_brn_low();
    cpu_BGn = 1'b0;
    cpu_ASn = 1'b1;
    cpu_DTACKn = 1'b1;
    for (int i = 0; i < 100 && !sub_br; i++) step();
    check("rst_pre_sub_br", sub_br, 1'b1);
    cpu_BGn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check("rst_bgackn", cpu_BGACKn, 1'b1);
    check("rst_sub_br", sub_br, 1'b0);
    check("rst_brn", cpu_BRn, 1'b1);
    check("rst_main_ok", main_ok, 1'b0);
    check("rst_main_din", main_din, 16'h0);
    check("rst_tout_err", tout_err, 1'b0);
    $display("txn: reset during access");
    err_model = 1'b0;
    main_cs = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step();
    check("rst_post_brn", cpu_BRn, 1'b1);
    check("rst_post_bgackn", cpu_BGACKn, 1'b1);
  endtask

  initial begin
    bit prev_b2b;
    bit cr, bb;
    repeat (3) step();
    check("reset_brn", cpu_BRn, 1'b1);
    check("reset_bgackn", cpu_BGACKn, 1'b1);
    check("reset_sub_br", sub_br, 1'b0);
    check("reset_main_ok", main_ok, 1'b0);
    check("reset_main_din", main_din, 16'h0);
    check("reset_tout_err", tout_err, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    normal_txn(1'b0, 3, 0, 1'b0, 4, 1'b0, 16'h1234);
    normal_txn(1'b0, 2, 3, 1'b0, 2, 1'b0, 16'($urandom));
    normal_txn(1'b0, 1, 0, 1'b0, 1, 1'b1, 16'($urandom));
    normal_txn(1'b0, 2, 2, 1'b0, 3, 1'b0, 16'($urandom));
    normal_txn(1'b1, 0, 0, 1'b0, 2, 1'b1, 16'($urandom));
    normal_txn(1'b0, 1, 0, 1'b1, 3, 1'b0, 16'($urandom));

    prev_b2b = 1'b0;
    for (int t = 0; t < 12; t++) begin
      cr = !prev_b2b && ($urandom_range(0, 3) == 0);
      bb = (t != 11) && ($urandom_range(0, 1) == 1);
      normal_txn(cr, $urandom_range(1, 6), $urandom_range(0, 4), ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 6), bb, 16'($urandom));
      prev_b2b = bb;
    end

    timeout_txn();
    normal_txn(1'b0, 2, 1, 1'b0, 2, 1'b0, 16'($urandom));
    reset_midop();
    normal_txn(1'b0, 1, 0, 1'b0, 1, 1'b0, 16'($urandom));

    repeat (4) step();
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
